// File: rtl/fb_pkg.sv
// Shared types for the framebuffer arbiter.
// Holds the CPU FSM and RAM owner-tag encodings.
package fb_pkg;

  localparam int FB_ADDR_WIDTH = 13;
  localparam int FB_DEPTH      = 8192;

  typedef enum logic [1:0] {
    C_IDLE   = 2'd0,
    C_ACCESS = 2'd1,
    C_DONE   = 2'd2
  } cstate_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DISP = 2'd1,
    OWN_CPU  = 2'd2
  } owner_e;

  function automatic logic [1:0] low_lane(input logic [3:0] m);
    low_lane = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (m[i]) low_lane = 2'(i);
  endfunction

endpackage

// File: rtl/fb_slot_timer.sv
// Free-running slot counter for the framebuffer arbiter.
// Count zero marks the display-owned slot.
module fb_slot_timer #(
  parameter int SLOT_PERIOD = 2,
  parameter int CW = $clog2(SLOT_PERIOD)
) (
  input  logic clk,
  input  logic rst_n,
  output logic display_slot_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (cnt_q == CW'(SLOT_PERIOD - 1)) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign display_slot_o = (cnt_q == '0);

endmodule

// File: rtl/fb_arbiter.sv
// Time-slotted arbiter sharing the framebuffer BRAM between
// the OLED pixel reader and byte-sequenced CPU word accesses.
module fb_arbiter
  import fb_pkg::*;
#(
  parameter int ADDR_WIDTH  = FB_ADDR_WIDTH,
  parameter int SLOT_PERIOD = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pixel_re,
  input  logic [ADDR_WIDTH-1:0] pixel_addr,
  output logic [7:0]            pixel_data,
  input  logic                  cpu_valid,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [31:0]           cpu_wdata,
  input  logic [3:0]            cpu_wstrb,
  output logic                  cpu_ready,
  output logic [31:0]           cpu_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [7:0]            ram_din,
  input  logic [7:0]            ram_q
);

  cstate_e               st_q, st_d;
  owner_e                own_q, own_d;
  logic [1:0]            olane_q, olane_d;
  logic                  we_q;
  logic [ADDR_WIDTH-3:0] wa_q;
  logic [31:0]           wd_q;
  logic [3:0]            pend_q, pend_d;
  logic [2:0]            lane_q, lane_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            pix_q;
  logic [31:0]           rdata_q;

  logic       disp_slot;
  logic       disp_go;
  logic       cpu_issue;
  logic [1:0] issue_lane;
  logic [1:0] unused_addr;

  fb_slot_timer #(.SLOT_PERIOD(SLOT_PERIOD)) u_slot (
    .clk            (clk),
    .rst_n          (rst_n),
    .display_slot_o (disp_slot)
  );

  assign unused_addr = cpu_addr[1:0];
  assign disp_go     = disp_slot & pixel_re;
  assign issue_lane  = we_q ? low_lane(pend_q) : lane_q[1:0];
  // The display slot always wins; the CPU lane waits for a free cycle
  assign cpu_issue   = (st_q == C_ACCESS) & ~disp_go &
                       (we_q ? (pend_q != 4'd0) : ~lane_q[2]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= C_IDLE;
      own_q   <= OWN_NONE;
      olane_q <= '0;
      we_q    <= 1'b0;
      wa_q    <= '0;
      wd_q    <= '0;
      pend_q  <= '0;
      lane_q  <= '0;
      addr_q  <= '0;
      pix_q   <= '0;
      rdata_q <= '0;
    end else begin
      st_q    <= st_d;
      own_q   <= own_d;
      olane_q <= olane_d;
      pend_q  <= pend_d;
      lane_q  <= lane_d;
      addr_q  <= ram_addr;
      if (st_q == C_IDLE && cpu_valid) begin
        we_q <= cpu_we;
        wa_q <= cpu_addr[ADDR_WIDTH-1:2];
        wd_q <= cpu_wdata;
      end
      if (own_q == OWN_DISP) pix_q <= ram_q;
      if (own_q == OWN_CPU)
        rdata_q[{olane_q, 3'b000} +: 8] <= ram_q;
    end
  end

  always_comb begin
    st_d   = st_q;
    pend_d = pend_q;
    lane_d = lane_q;
    unique case (st_q)
      C_IDLE: begin
        if (cpu_valid) begin
          pend_d = cpu_wstrb;
          lane_d = 3'd0;
          st_d   = (cpu_we && cpu_wstrb == 4'd0) ? C_DONE : C_ACCESS;
        end
      end
      C_ACCESS: begin
        if (we_q) begin
          if (cpu_issue) begin
            pend_d = pend_q & (pend_q - 4'd1);
            if (pend_d == 4'd0) st_d = C_DONE;
          end
        end else begin
          if (cpu_issue) lane_d = lane_q + 3'd1;
          if (own_q == OWN_CPU && olane_q == 2'd3) st_d = C_DONE;
        end
      end
      C_DONE:  st_d = C_IDLE;
      default: st_d = C_IDLE;
    endcase
  end

  always_comb begin
    ram_addr  = addr_q;
    ram_we    = 1'b0;
    ram_din   = 8'd0;
    own_d     = OWN_NONE;
    olane_d   = olane_q;
    cpu_ready = (st_q == C_DONE);
    if (disp_go) begin
      ram_addr = pixel_addr;
      own_d    = OWN_DISP;
    end else if (cpu_issue) begin
      ram_addr = {wa_q, issue_lane};
      ram_we   = we_q;
      if (we_q) begin
        ram_din = wd_q[{issue_lane, 3'b000} +: 8];
      end else begin
        own_d   = OWN_CPU;
        olane_d = issue_lane;
      end
    end
  end

  assign pixel_data = pix_q;
  assign cpu_rdata  = rdata_q;

endmodule

// File: tb/tb_fb_arbiter.sv
// Self-checking bench for fb_arbiter with a behavioural BRAM
// and a byte-level scoreboard of framebuffer contents.
module tb_fb_arbiter;

  localparam int AW = 13;
  localparam int P  = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pixel_re;
  logic [AW-1:0] pixel_addr;
  logic [7:0]    pixel_data;
  logic          cpu_valid;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [31:0]   cpu_wdata;
  logic [3:0]    cpu_wstrb;
  logic          cpu_ready;
  logic [31:0]   cpu_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [7:0]    ram_din;
  logic [7:0]    ram_q;

  always #5 clk = ~clk;

  fb_arbiter #(.ADDR_WIDTH(AW), .SLOT_PERIOD(P)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pixel_re   (pixel_re),
    .pixel_addr (pixel_addr),
    .pixel_data (pixel_data),
    .cpu_valid  (cpu_valid),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_wstrb  (cpu_wstrb),
    .cpu_ready  (cpu_ready),
    .cpu_rdata  (cpu_rdata),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_din    (ram_din),
    .ram_q      (ram_q)
  );

  logic [7:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_q <= mem[ram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slot number of the current cycle, restarted by reset
  int tcnt;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) tcnt <= 0;
    else        tcnt <= (tcnt == P - 1) ? 0 : tcnt + 1;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  ref_mem [int];
  logic [31:0] last_rd = 32'd0;
  int          pa_t = 0;
  bit          chk_pix = 1'b0;
  bit          step_pix = 1'b0;

  task automatic cpu_xfer(input logic we, input logic [AW-1:0] addr,
                          input logic [31:0] wd, input logic [3:0] strb,
                          input logic prx);
    logic [AW-1:0] base;
    logic [AW-1:0] ea[$];
    logic [7:0]    ed[$];
    logic [31:0]   exp_rd;
    int need, k, c, last, exp_rdy, cnt0, got, age;
    base = {addr[AW-1:2], 2'b00};
    exp_rd = last_rd;
    for (int i = 0; i < 4; i++) begin
      if (we && strb[i]) begin
        ea.push_back(base + AW'(i));
        ed.push_back(wd[8*i +: 8]);
        ref_mem[int'(base) + i] = wd[8*i +: 8];
      end
      if (!we)
        exp_rd[8*i +: 8] = ref_mem.exists(int'(base) + i) ?
                           ref_mem[int'(base) + i] : 8'h00;
    end
    need = we ? ea.size() : 4;
    cnt0 = tcnt;
    c = 0; k = 0; last = 0;
    while (k < need) begin
      c++;
      if (!(prx && ((cnt0 + c) % P) == 0)) begin
        k++;
        last = c;
      end
    end
    exp_rdy = we ? last + 1 : last + 2;
    if (!we) last_rd = exp_rd;
    pixel_re  = prx;
    cpu_valid = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wd;
    cpu_wstrb = strb;
    got = 0;
    for (int cc = 1; cc <= 80; cc++) begin
      @(posedge clk); #1;
      age = cyc - pa_t;
      if (chk_pix && pixel_re && age >= P + 1) begin
        n_cmp++;
        if (pixel_data !== ref_mem[int'(pixel_addr)]) begin
          n_bad++;
          $display("FAIL pixel_track addr=%h got=%h want=%h",
                   pixel_addr, pixel_data, ref_mem[int'(pixel_addr)]);
        end
      end
      if (step_pix && age >= 4) begin
        pixel_addr = AW'((pixel_addr + 13'd1) & 13'd3);
        pa_t = cyc;
      end
      if (got != 0) begin
        n_cmp++;
        if (cpu_ready !== 1'b0 || cpu_rdata !== exp_rd) begin
          n_bad++;
          $display("FAIL ready_pulse ready=%b rdata=%h want 0/%h",
                   cpu_ready, cpu_rdata, exp_rd);
        end
        break;
      end
      if (ram_we) begin
        n_cmp++;
        if (ea.size() == 0 || ram_addr !== ea[0] || ram_din !== ed[0] ||
            (prx && tcnt == 0)) begin
          n_bad++;
          $display("FAIL ram_write cyc=%0d got %h=%h slot=%0d want %h=%h",
                   cc, ram_addr, ram_din, tcnt,
                   ea.size() ? ea[0] : '0, ed.size() ? ed[0] : 8'h0);
        end
        if (ea.size() != 0) begin
          void'(ea.pop_front());
          void'(ed.pop_front());
        end
      end
      if (cpu_ready) begin
        n_cmp++;
        if (cc != exp_rdy || cpu_rdata !== exp_rd) begin
          n_bad++;
          $display("FAIL ready_time got cyc=%0d rdata=%h want cyc=%0d rdata=%h",
                   cc, cpu_rdata, exp_rdy, exp_rd);
        end
        cpu_valid = 1'b0;
        got = cc;
      end
    end
    n_cmp++;
    if (got == 0 || ea.size() != 0) begin
      n_bad++;
      $display("FAIL xfer_end got ready_cyc=%0d left=%0d want %0d/0",
               got, ea.size(), exp_rdy);
    end
    cpu_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pixel_re = 1'b0; pixel_addr = '0;
    cpu_valid = 1'b0; cpu_we = 1'b0; cpu_addr = '0;
    cpu_wdata = '0; cpu_wstrb = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (pixel_data !== 8'd0 || cpu_ready !== 1'b0 || cpu_rdata !== 32'd0 ||
        ram_we !== 1'b0 || ram_addr !== '0 || ram_din !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_vals pd=%h rdy=%b rd=%h we=%b a=%h d=%h want all 0",
               pixel_data, cpu_ready, cpu_rdata, ram_we, ram_addr, ram_din);
    end
    pixel_re = 1'b1;
    pixel_addr = 13'h0AB;
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (ram_addr !== 13'h0AB) begin
      n_bad++;
      $display("FAIL reset_slot0 got=%h want=0ab", ram_addr);
    end
    @(posedge clk); #1;
    pixel_addr = 13'h0CD;
    #1;
    n_cmp++;
    if (ram_addr !== 13'h0AB || ram_we !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_slot1 got=%h we=%b want=0ab/0", ram_addr, ram_we);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (ram_addr !== 13'h0CD) begin
      n_bad++;
      $display("FAIL reset_slot2 got=%h want=0cd", ram_addr);
    end
    pixel_re = 1'b0;
  endtask

  task automatic test_write_full();
    cpu_xfer(1'b1, 13'h0010, 32'hA1B2C3D4, 4'hF, 1'b0);
  endtask

  task automatic test_contended_read();
    cpu_xfer(1'b1, 13'h0004, 32'h00005A00, 4'b0010, 1'b0);
    pixel_addr = 13'h0005;
    pa_t = cyc;
    chk_pix = 1'b1;
    cpu_xfer(1'b0, 13'h0010, 32'd0, 4'd0, 1'b1);
    chk_pix = 1'b0;
    n_cmp++;
    if (cpu_rdata !== 32'hA1B2C3D4 || pixel_data !== 8'h5A) begin
      n_bad++;
      $display("FAIL contended got rd=%h pd=%h want a1b2c3d4/5a",
               cpu_rdata, pixel_data);
    end
  endtask

  task automatic test_partial_strobe();
    cpu_xfer(1'b1, 13'h0010, 32'h11223344, 4'b0101, 1'b0);
    cpu_xfer(1'b0, 13'h0010, 32'd0, 4'd0, 1'b0);
  endtask

  task automatic test_empty_strobe();
    cpu_xfer(1'b1, 13'h0010, 32'hDEADBEEF, 4'b0000, 1'b0);
    cpu_xfer(1'b0, 13'h0010, 32'd0, 4'd0, 1'b0);
  endtask

  task automatic test_display_tracking();
    cpu_xfer(1'b1, 13'h0000, 32'h03020100, 4'hF, 1'b0);
    pixel_addr = 13'h0000;
    pa_t = cyc;
    chk_pix = 1'b1;
    step_pix = 1'b1;
    for (int i = 0; i < 6; i++)
      cpu_xfer(1'b1, AW'(13'h0200 + 4 * i), $urandom, 4'hF, 1'b1);
    chk_pix = 1'b0;
    step_pix = 1'b0;
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    for (int i = 0; i < 6; i++) begin
      a = AW'(13'h0400 + 4 * $urandom_range(0, 255));
      cpu_xfer(1'b1, a, $urandom, 4'hF, 1'($urandom_range(0, 1)));
      cpu_xfer(1'b1, a, $urandom, 4'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)));
      cpu_xfer(1'b0, a, 32'd0, 4'd0, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid();
    int nw;
    bit saw;
    cpu_xfer(1'b1, 13'h0040, 32'h11223344, 4'hF, 1'b0);
    pixel_re = 1'b0;
    cpu_valid = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0040;
    cpu_wdata = 32'hAABBCCDD; cpu_wstrb = 4'hF;
    nw = 0;
    for (int c = 0; c < 10 && nw < 2; c++) begin
      @(posedge clk); #1;
      if (ram_we) nw++;
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    cpu_valid = 1'b0;
    #1;
    n_cmp++;
    if (nw != 2 || ram_we !== 1'b0 || cpu_ready !== 1'b0 ||
        cpu_rdata !== 32'd0 || pixel_data !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_mid lanes=%0d we=%b rdy=%b rd=%h pd=%h want 2/0/0/0/0",
               nw, ram_we, cpu_ready, cpu_rdata, pixel_data);
    end
    last_rd = 32'd0;
    ref_mem[32'h40] = 8'hDD;
    ref_mem[32'h41] = 8'hCC;
    @(posedge clk); #1;
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (cpu_ready || ram_we) saw = 1'b1;
    end
    n_cmp++;
    if (saw) begin
      n_bad++;
      $display("FAIL reset_mid_quiet got ready/we activity want none");
    end
    cpu_xfer(1'b0, 13'h0040, 32'd0, 4'd0, 1'b0);
    cpu_xfer(1'b1, 13'h0040, 32'h5566_7788, 4'hF, 1'b1);
    cpu_xfer(1'b0, 13'h0040, 32'd0, 4'd0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_write_full();
    test_contended_read();
    test_partial_strobe();
    test_empty_strobe();
    test_display_tracking();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fb_arbiter.md
Name: fb_arbiter

Overview:
Shares the single-port 8192x8 framebuffer BRAM between the OLED display controller's pixel read port and the 32-bit CPU bus. The block time-slots the RAM so display reads get a bounded, guaranteed latency. CPU word accesses are sequenced into byte-lane RAM cycles in the remaining slots. It sits between the CPU bus decoder, the OLED controller (pixel_re/pixel_addr/pixel_data) and the framebuffer BRAM.

Parameters:
ADDR_WIDTH, 13, framebuffer byte-address width (depth = 2**ADDR_WIDTH).
SLOT_PERIOD, 2, cycles per slot frame; the display owns 1 of every SLOT_PERIOD cycles while pixel_re=1 (legal range 2..16).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
pixel_re  in  1  display read enable (level)
pixel_addr  in  ADDR_WIDTH  display byte address
pixel_data  out  8  registered display read data
cpu_valid  in  1  CPU request; held until cpu_ready
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_WIDTH  CPU byte address; bits [1:0] ignored (word aligned)
cpu_wdata  in  32  write data, little-endian lanes
cpu_wstrb  in  4  byte-lane write strobes
cpu_ready  out  1  one-cycle completion pulse
cpu_rdata  out  32  read data, valid while cpu_ready=1 and held afterwards
ram_addr  out  ADDR_WIDTH  BRAM address
ram_we  out  1  BRAM write enable
ram_din  out  8  BRAM write data
ram_q  in  8  BRAM read data, 1-cycle synchronous read

Behaviour:
- Reset (rst_n=0, asynchronous): pixel_data=0, cpu_ready=0, cpu_rdata=0, ram_we=0, ram_addr=0, ram_din=0, slot counter=0, CPU FSM=C_IDLE, owner tag cleared. An in-flight CPU transaction is discarded and no cpu_ready is issued for it.
- Slot counter: free-running 0..SLOT_PERIOD-1, wraps to 0. Count 0 is the display slot; all other counts are CPU slots.
- Display slot with pixel_re=1: ram_addr=pixel_addr, ram_we=0, owner tag=DISP for the next cycle. ram_q is registered into pixel_data at the end of the following cycle. pixel_data holds between captures.
- Display latency: pixel_data reflects a stable pixel_addr within SLOT_PERIOD+1 cycles. The requester must hold pixel_addr at least that long.
- Display slot with pixel_re=0: the cycle is treated as a CPU slot.
- CPU FSM states: C_IDLE, C_ACCESS, C_DONE.
- C_IDLE: when cpu_valid=1, latch we/addr/wdata/wstrb, set lane=0, go to C_ACCESS. If the request is a write with wstrb=0000, go straight to C_DONE.
- C_ACCESS, writes: in each CPU slot, advance to the next set strobe lane i and drive ram_addr={addr[AW-1:2],i}, ram_we=1, ram_din=wdata[8i+7:8i]. Unset lanes cost no cycles. After the last set lane, go to C_DONE.
- C_ACCESS, reads: in each CPU slot, issue lanes 0..3 in order with ram_we=0 and owner tag=CPU/lane. The cycle after each issue, ram_q goes into cpu_rdata[8*lane+7:8*lane]. After lane 3 is captured, go to C_DONE.
- C_DONE: cpu_ready=1 for exactly one cycle, then C_IDLE. The earliest next acceptance is the cycle after cpu_ready.
- ram_q routing: determined solely by the owner tag of the previous cycle's issue. A display capture never corrupts a CPU byte, and vice versa.
- Non-access cycles: ram_we=0; ram_addr holds its last value.
- Timing, pixel_re=0, request accepted cycle 0: a full-strobe write issues lanes in cycles 1-4 with cpu_ready in cycle 5; a read issues lanes in cycles 1-4 with cpu_ready in cycle 6.
- With pixel_re=1 and SLOT_PERIOD=2, these times roughly double.
- cpu_valid dropping or request fields changing before cpu_ready is a protocol violation. The latched copy is used.
- Simultaneous events: a display slot always wins the cycle, even mid CPU transaction. The CPU lane stalls to the next CPU slot.

Decomposition:
- Package fb_pkg: FB_ADDR_WIDTH=13, FB_DEPTH=8192, CPU FSM state encoding (C_IDLE/C_ACCESS/C_DONE), owner-tag encoding (NONE/DISP/CPU).
- One sub-module, fb_slot_timer: slot counter plus display_slot flag, parameterised by SLOT_PERIOD.

Test Plan:
- Reset: assert rst_n=0 mid-run -> pixel_data=0, cpu_ready=0, cpu_rdata=0, ram_we=0 immediately. After release, the counter restarts at 0.
- Full write, pixel_re=0: write 0xA1B2C3D4 to 0x0010, wstrb=1111 -> ram writes 0x10=D4, 0x11=C3, 0x12=B2, 0x13=A1 in cycles 1-4; cpu_ready=1 in cycle 5 only.
- Partial/empty strobe: wstrb=0101, data 0x11223344 -> only 0x10=44 and 0x12=22 written, cpu_ready cycle 3. wstrb=0000 -> no ram_we, cpu_ready in the cycle after acceptance.
- Contended read: RAM 0x0005=0x5A, bytes 0x10..0x13 as above; pixel_re=1, pixel_addr=0x0005; CPU reads 0x0010 -> pixel_data=0x5A within 3 cycles and unchanged. cpu_rdata=0xA1B2C3D4. CPU RAM accesses occur only on counter=1 cycles.
- Display tracking: pixel_addr steps 0x0000..0x0003 every 4 cycles over RAM 0x00,0x01,0x02,0x03 while CPU writes run continuously -> pixel_data equals each byte within 3 cycles of the address change. No CPU byte is ever routed to pixel_data.
- Reset mid-transaction: assert rst_n after 2 write lanes -> ram_we=0 at once, no cpu_ready for that transaction. A new write after release completes normally.
